bitty_alu_sequencer: RTL
========================

# bitty_alu_sequencer

Multi-cycle control unit that sequences the Bitty 16-bit ALU. It accepts one instruction at a time over a valid/ready handshake and decodes it. It reads operands from an internal 8x16 register file, drives the ALU operand and select lines, captures the result, writes it back to the destination register, and pulses `done`. It sits between the instruction source (fetch stage or testbench) and the purely combinational ALU, which is instantiated beside it at the processor top level.

## Interface
Parameters:
- `NREGS`, 8: register-file depth; fixed by the 3-bit register fields.
- `W`, 16: datapath width.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  16  instruction word, sampled on the handshake.
- `instr_valid`  in  1  `instr` is valid.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `alu_a`  out  16  ALU operand A.
- `alu_b`  out  16  ALU operand B.
- `alu_sel`  out  3  ALU operation select: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 cmp.
- `alu_result`  in  16  combinational ALU output.
- `done`  out  1  one-cycle pulse: instruction completing.
- `result_out`  out  16  result of the most recent completed ALU instruction.
- `dbg_sel`  in  3  debug register index.
- `dbg_data`  out  16  combinational read of `rf[dbg_sel]`.

## Operation
- Decode fields:
  - `rx` = instr[15:13] (destination and operand A).
  - `ry` = instr[12:10].
  - `imm8` = instr[12:5].
  - `sel` = instr[4:2].
  - `fmt` = instr[1:0].
- Formats:
  - `fmt` 00, reg-reg: B = `rf[ry]`.
  - `fmt` 01, reg-imm: B = {8'h00, `imm8`}, zero-extended.
  - `fmt` 10/11, reserved: NOP. The instruction runs the full sequence and pulses `done`. It writes no register and leaves `result_out` unchanged.
- The instruction register `ir` captures `instr` when `instr_valid && instr_ready`.
- FSM states:
  - IDLE: `instr_ready`=1. On handshake go to FETCH, else stay.
  - FETCH: `reg_a <= rf[ir.rx]`. Go to EXEC.
  - EXEC: ALU inputs are valid this cycle. `reg_c <= alu_result`. Go to WB.
  - WB: `done`=1. At the closing edge, if `fmt` is 0x, `rf[ir.rx] <= reg_c` and `result_out <= reg_c`. Go to IDLE.
- ALU drive, all derived from registers only:
  - `alu_a` = `reg_a`.
  - `alu_b` = format mux over `rf[ir.ry]` or `imm8`.
  - `alu_sel` = `ir[4:2]`.
  - These lines are meaningful only in EXEC.
- `rx == ry` is legal. A is read in FETCH and B in EXEC; no write occurs between them, so both operands equal `rf[rx]`.
- The ALU result is taken verbatim, with no flags or saturation. The cmp result (0/1/2) is written back like any other result.
- `instr_valid` outside IDLE is ignored. The source holds `instr` until `instr_ready` is seen.

## Timing
- Reset (`rst_n`=0, asynchronous): all outputs and state return immediately.
  - State = IDLE.
  - `ir`, `reg_a`, `reg_c`, `result_out` = 0.
  - All 8 `rf` entries = 0.
  - `done` = 0; `instr_ready` = 1 once `rst_n` is high.
  - Reset asserted mid-instruction aborts it: no write-back and no `done`.
- Latency: handshake at edge N. FETCH runs in cycle N..N+1, EXEC in N+1..N+2, and WB (`done` high) in N+2..N+3.
  - `rf` and `result_out` update at edge N+3.
  - IDLE with `instr_ready`=1 in the cycle after edge N+3.
- Throughput: at most one instruction per 4 cycles. The earliest next handshake is edge N+4.
- `dbg_data` reflects a write-back in the cycle after edge N+3.
- `done` is exactly one cycle wide per accepted instruction, NOPs included.

## Test plan
- Reset: hold `rst_n`=0, then release → `instr_ready`=1, `done`=0, `result_out`=0, `dbg_data`=0 for all 8 `dbg_sel`. Assert `rst_n` low in EXEC of 0x20A1 → no `done`, r1 stays 0.
- Immediate add: 0x20A1 (r1+=5), then 0x4061 (r2+=3) → r1=5, r2=3. `done` occurs exactly 3 edges after each handshake; `result_out`=5, then 3.
- Reg-reg sub: r1=5, r2=3; issue 0x2804 (r1=r1-r2) → in EXEC `alu_a`=5, `alu_b`=3, `alu_sel`=1; after completion r1=2, `result_out`=2.
- Compare: r1=5, r2=3; issue 0x281C (cmp r1,r2) → r1=1. Then issue cmp with r1=1, r2=3 → r1=2.
- NOP and ignored valid:
  - 0x20A2 → `done` pulses once; r1 and `result_out` unchanged.
  - `instr_valid` held high continuously → one accept per 4 cycles; `instr` changes during FETCH/EXEC/WB have no effect.
- Self-operand: r3=4, issue `rx`=`ry`=3 add reg-reg (0x6C00) → r3=8; `alu_a`=`alu_b`=4 in EXEC.

Source files
------------

// File: rtl/bitty_alu_sequencer.sv
// Multi-cycle control unit for the Bitty 16-bit ALU: accepts one instruction,
// reads operands from an 8x16 register file, drives the external ALU and writes back.
module bitty_alu_sequencer #(
  parameter int NREGS = 8,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  instr,
  input  logic         instr_valid,
  output logic         instr_ready,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_sel,
  input  logic [W-1:0] alu_result,
  output logic         done,
  output logic [W-1:0] result_out,
  input  logic [2:0]   dbg_sel,
  output logic [W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t         state_r;
  logic [15:0]    ir_r;
  logic [W-1:0]   reg_a_r;
  logic [W-1:0]   reg_c_r;
  logic [W-1:0]   result_r;
  logic           done_r;
  logic           ready_r;
  logic [W-1:0]   rf_r [NREGS];

  logic [2:0]     ir_rx_s;
  logic [2:0]     ir_ry_s;
  logic [7:0]     ir_imm_s;
  logic [2:0]     ir_sel_s;
  logic [1:0]     ir_fmt_s;
  logic           handshake_s;
  logic           wb_we_s;

  assign ir_rx_s     = ir_r[15:13];
  assign ir_ry_s     = ir_r[12:10];
  assign ir_imm_s    = ir_r[12:5];
  assign ir_sel_s    = ir_r[4:2];
  assign ir_fmt_s    = ir_r[1:0];
  assign handshake_s = instr_valid && ready_r;

  // Reserved formats (1x) run the full sequence but commit nothing.
  assign wb_we_s     = (state_r == S_WB) && (ir_fmt_s[1] == 1'b0);

  assign instr_ready = ready_r;
  assign done        = done_r;
  assign result_out  = result_r;

  // ALU drive comes only from registered state so it is stable throughout EXEC.
  assign alu_a   = reg_a_r;
  assign alu_sel = ir_sel_s;
  assign alu_b   = (ir_fmt_s == 2'b01) ? {{(W-8){1'b0}}, ir_imm_s} : rf_r[ir_ry_s];

  assign dbg_data = rf_r[dbg_sel];

  // Sequencer FSM with its registered handshake, done and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      ir_r     <= 16'h0000;
      reg_a_r  <= '0;
      reg_c_r  <= '0;
      result_r <= '0;
      done_r   <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (handshake_s) begin
            ir_r    <= instr;
            ready_r <= 1'b0;
            state_r <= S_FETCH;
          end else begin
            ready_r <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        S_FETCH: begin
          reg_a_r <= rf_r[ir_rx_s];
          state_r <= S_EXEC;
        end
        S_EXEC: begin
          reg_c_r <= alu_result;
          done_r  <= 1'b1;
          state_r <= S_WB;
        end
        S_WB: begin
          if (ir_fmt_s[1] == 1'b0) begin
            result_r <= reg_c_r;
          end else begin
            result_r <= result_r;
          end
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= S_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Register file: cleared on reset, written only at the closing edge of WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_r[i] <= '0;
      end
    end else begin
      if (wb_we_s) begin
        rf_r[ir_rx_s] <= reg_c_r;
      end
    end
  end

endmodule
